mem_ctrl: RTL and testbench

- Byte-serial memory access controller between the MEM stage and an 8-bit synchronous RAM port.
- Accepts one load/store request at a time from MEM and splits it into 1/2/4 byte accesses.
- For loads: assembles little-endian bytes, then sign- or zero-extends them into a 32-bit result.
- Raises a stall request so the pipeline freezes until the access completes.

---
 rtl/mem_ctrl_pkg.sv | 39 +++
 rtl/mem_ctrl_if.sv | 23 ++
 rtl/mem_load_ext.sv | 20 ++
 rtl/mem_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_mem_ctrl.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared encodings and helpers for the byte-serial memory controller.
// Also used by the MEM stage for load-extension forwarding checks.
package mem_ctrl_pkg;

  localparam int unsigned RamAddrW = 17;

  // Access size encodings; 2'd3 is reserved and behaves as a word.
  localparam logic [1:0] MemByte = 2'd0;
  localparam logic [1:0] MemHalf = 2'd1;
  localparam logic [1:0] MemWord = 2'd2;

  typedef enum logic [1:0] {
    McIdle = 2'd0,
    McXfer = 2'd1,
    McDone = 2'd2
  } mc_state_e;

  function automatic logic [2:0] size_nbytes(input logic [1:0] size);
    logic [2:0] n;
    case (size)
      MemByte: n = 3'd1;
      MemHalf: n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

  function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// MEM-stage side of the memory controller: request fields in, status and load data out.
interface mem_ctrl_if;
  logic        req_i;
  logic        we_i;
  logic [1:0]  size_i;
  logic        sext_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] rdata_o;
  logic        stall_req_o;

  modport master (
    output req_i, we_i, size_i, sext_i, addr_i, wdata_i,
    input  busy_o, done_o, rdata_o, stall_req_o
  );

  modport slave (
    input  req_i, we_i, size_i, sext_i, addr_i, wdata_i,
    output busy_o, done_o, rdata_o, stall_req_o
  );
endinterface

// File: rtl/mem_load_ext.sv
// Combinational sign/zero extension of an assembled load word by access size.
module mem_load_ext
  import mem_ctrl_pkg::*;
(
  input  logic [31:0] data_i,
  input  logic [1:0]  size_i,
  input  logic        sext_i,
  output logic [31:0] data_o
);

  always_comb begin
    data_o = data_i;
    case (size_i)
      MemByte: data_o = {{24{sext_i & data_i[7]}}, data_i[7:0]};
      MemHalf: data_o = {{16{sext_i & data_i[15]}}, data_i[15:0]};
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial load/store controller between the MEM stage and an 8-bit synchronous RAM.
// Optional MEM_CTRL_PERF_EN adds load/store/stall performance counters.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = RamAddrW
) (
  input  logic              clk,
  input  logic              rst,
  mem_ctrl_if.slave         mem,
  output logic [ADDR_W-1:0] ram_a_o,
  output logic [7:0]        ram_dout_o,
  output logic              ram_wr_o,
  input  logic [7:0]        ram_din_i
`ifdef MEM_CTRL_PERF_EN
  ,
  output logic [31:0]       perf_ld_o,
  output logic [31:0]       perf_st_o,
  output logic [31:0]       perf_stall_o
`endif
);

  mc_state_e         state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [2:0]        nb_q, nb_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              sext_q, sext_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       asm_q, asm_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [ADDR_W-1:0] ram_a_q, ram_a_d;
  logic [7:0]        ram_dout_q, ram_dout_d;
  logic              ram_wr_q, ram_wr_d;

  logic [2:0]  cnt_nxt;
  logic [31:0] asm_ins;
  logic [31:0] ext_word;
  logic        busy, done, stall;

  generate
    if (ADDR_W < 32) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^mem.addr_i[31:ADDR_W];
    end
  endgenerate

  assign cnt_nxt = cnt_q + 3'd1;

  // RAM data lags its address by one cycle, so counter value c delivers byte c-1.
  always_comb begin
    asm_ins = asm_q;
    case (cnt_q)
      3'd1:    asm_ins[7:0]   = ram_din_i;
      3'd2:    asm_ins[15:8]  = ram_din_i;
      3'd3:    asm_ins[23:16] = ram_din_i;
      3'd4:    asm_ins[31:24] = ram_din_i;
      default: ;
    endcase
  end

  mem_load_ext u_load_ext (
    .data_i (asm_ins),
    .size_i (size_q),
    .sext_i (sext_q),
    .data_o (ext_word)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    nb_d       = nb_q;
    we_d       = we_q;
    size_d     = size_q;
    sext_d     = sext_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    asm_d      = asm_q;
    rdata_d    = rdata_q;
    ram_a_d    = ram_a_q;
    ram_dout_d = ram_dout_q;
    ram_wr_d   = ram_wr_q;

    unique case (state_q)
      McIdle: begin
        if (mem.req_i) begin
          state_d    = McXfer;
          cnt_d      = 3'd0;
          nb_d       = size_nbytes(mem.size_i);
          we_d       = mem.we_i;
          size_d     = mem.size_i;
          sext_d     = mem.sext_i;
          addr_d     = mem.addr_i[ADDR_W-1:0];
          wdata_d    = mem.wdata_i;
          asm_d      = 32'd0;
          ram_a_d    = mem.addr_i[ADDR_W-1:0];
          ram_dout_d = mem.wdata_i[7:0];
          ram_wr_d   = mem.we_i;
        end
      end
      McXfer: begin
        cnt_d = cnt_nxt;
        if (!we_q) begin
          asm_d = asm_ins;
        end
        if (we_q && (cnt_q == nb_q - 3'd1)) begin
          state_d  = McDone;
          ram_wr_d = 1'b0;
        end else if (!we_q && (cnt_q == nb_q)) begin
          state_d = McDone;
          rdata_d = ext_word;
        end else if (cnt_q < nb_q - 3'd1) begin
          ram_a_d    = addr_q + ADDR_W'(cnt_nxt);
          ram_dout_d = byte_sel(wdata_q, cnt_nxt[1:0]);
        end
        // A load's final count is the drain cycle: address held, nothing issued.
      end
      McDone: begin
        state_d = McIdle;
        cnt_d   = 3'd0;
      end
      default: state_d = McIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= McIdle;
      cnt_q      <= 3'd0;
      nb_q       <= 3'd0;
      we_q       <= 1'b0;
      size_q     <= MemByte;
      sext_q     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= 32'd0;
      asm_q      <= 32'd0;
      rdata_q    <= 32'd0;
      ram_a_q    <= '0;
      ram_dout_q <= 8'd0;
      ram_wr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      nb_q       <= nb_d;
      we_q       <= we_d;
      size_q     <= size_d;
      sext_q     <= sext_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      asm_q      <= asm_d;
      rdata_q    <= rdata_d;
      ram_a_q    <= ram_a_d;
      ram_dout_q <= ram_dout_d;
      ram_wr_q   <= ram_wr_d;
    end
  end

  assign busy  = (state_q != McIdle);
  assign done  = (state_q == McDone);
  assign stall = (mem.req_i | busy) & ~done;

  assign mem.busy_o      = busy;
  assign mem.done_o      = done;
  assign mem.rdata_o     = rdata_q;
  assign mem.stall_req_o = stall;

  assign ram_a_o    = ram_a_q;
  assign ram_dout_o = ram_dout_q;
  // Gated so a reset landing mid-store cannot commit the in-flight byte.
  assign ram_wr_o   = ram_wr_q & ~rst;

`ifdef MEM_CTRL_PERF_EN
  logic [31:0] perf_ld_q, perf_st_q, perf_stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_ld_q    <= 32'd0;
      perf_st_q    <= 32'd0;
      perf_stall_q <= 32'd0;
    end else begin
      if (done && we_q) begin
        perf_st_q <= perf_st_q + 32'd1;
      end
      if (done && !we_q) begin
        perf_ld_q <= perf_ld_q + 32'd1;
      end
      if (stall) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end

  assign perf_ld_o    = perf_ld_q;
  assign perf_st_o    = perf_st_q;
  assign perf_stall_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a behavioural 8-bit synchronous RAM.
module tb_mem_ctrl;

  logic        clk;
  logic        rst;
  logic [16:0] ram_a;
  logic [7:0]  ram_dout;
  logic        ram_wr;
  logic [7:0]  ram_din;
`ifdef MEM_CTRL_PERF_EN
  logic [31:0] perf_ld, perf_st, perf_stall;
`endif

  mem_ctrl_if mif ();

  mem_ctrl #(
    .ADDR_W (17)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mem        (mif),
    .ram_a_o    (ram_a),
    .ram_dout_o (ram_dout),
    .ram_wr_o   (ram_wr),
    .ram_din_i  (ram_din)
`ifdef MEM_CTRL_PERF_EN
    ,
    .perf_ld_o    (perf_ld),
    .perf_st_o    (perf_st),
    .perf_stall_o (perf_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] ram [0:131071];

  always @(posedge clk) begin
    ram_din <= ram[ram_a];
    if (ram_wr) ram[ram_a] = ram_dout;
  end

  int n_chk;
  int n_bad;

  logic [16:0] log_a [10];
  logic        log_w [10];
  logic [7:0]  log_d [10];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Starts at a negedge in IDLE; returns at the negedge of the cycle after done_o.
  task automatic xfer(input logic we, input logic [1:0] sz, input logic sx,
                      input logic [31:0] a, input logic [31:0] wd, input logic hold,
                      output int dc);
    mif.req_i   = 1'b1;
    mif.we_i    = we;
    mif.size_i  = sz;
    mif.sext_i  = sx;
    mif.addr_i  = a;
    mif.wdata_i = wd;
    #1 check("req_stall", 32'(mif.stall_req_o), 32'd1);
    dc = -1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      log_a[c] = ram_a;
      log_w[c] = ram_wr;
      log_d[c] = ram_dout;
      if (mif.done_o) begin
        dc = c;
        break;
      end
    end
    if (!hold) mif.req_i = 1'b0;
    @(negedge clk);
    check("idle_busy", 32'(mif.busy_o), 32'd0);
    check("idle_stall", 32'(mif.stall_req_o), 32'(hold));
  endtask

  int dc;
  logic seen_done;

  initial begin
    n_chk = 0;
    n_bad = 0;
    for (int i = 0; i < 131072; i++) ram[i] = 8'h00;
    rst = 1'b1;
    mif.req_i = 1'b0;
    mif.we_i = 1'b0;
    mif.size_i = 2'd0;
    mif.sext_i = 1'b0;
    mif.addr_i = 32'd0;
    mif.wdata_i = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(mif.busy_o), 32'd0);
    check("rst_done", 32'(mif.done_o), 32'd0);
    check("rst_rdata", mif.rdata_o, 32'd0);
    check("rst_ram_a", 32'(ram_a), 32'd0);
    check("rst_ram_dout", 32'(ram_dout), 32'd0);
    check("rst_ram_wr", 32'(ram_wr), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Word store 0xDEADBEEF @0x100
    xfer(1'b1, 2'd2, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 1'b0, dc);
    check("st_done_cycle", 32'(dc), 32'd4);
    check("st_a0", 32'(log_a[0]), 32'h100);
    check("st_a3", 32'(log_a[3]), 32'h103);
    check("st_w0", 32'(log_w[0]), 32'd1);
    check("st_w3", 32'(log_w[3]), 32'd1);
    check("st_w_done", 32'(log_w[4]), 32'd0);
    check("st_d0", 32'(log_d[0]), 32'hEF);
    check("st_d1", 32'(log_d[1]), 32'hBE);
    check("st_d2", 32'(log_d[2]), 32'hAD);
    check("st_d3", 32'(log_d[3]), 32'hDE);
    check("st_ram", {ram[17'h103], ram[17'h102], ram[17'h101], ram[17'h100]}, 32'hDEAD_BEEF);
    check("st_rdata_kept", mif.rdata_o, 32'd0);

    // Signed and unsigned byte loads @0x100
    xfer(1'b0, 2'd0, 1'b1, 32'h0000_0100, 32'd0, 1'b0, dc);
    check("lb_done_cycle", 32'(dc), 32'd2);
    check("lb_rdata", mif.rdata_o, 32'hFFFF_FFEF);
    check("lb_w0", 32'(log_w[0]), 32'd0);
    xfer(1'b0, 2'd0, 1'b0, 32'h0000_0100, 32'd0, 1'b0, dc);
    check("lbu_rdata", mif.rdata_o, 32'h0000_00EF);

    // Half load across the address wrap
    ram[17'h1FFFF] = 8'h34;
    ram[17'h00000] = 8'h82;
    xfer(1'b0, 2'd1, 1'b1, 32'h0001_FFFF, 32'd0, 1'b0, dc);
    check("lh_done_cycle", 32'(dc), 32'd3);
    check("lh_a0", 32'(log_a[0]), 32'h1FFFF);
    check("lh_a1", 32'(log_a[1]), 32'h00000);
    check("lh_a_drain", 32'(log_a[2]), 32'h00000);
    check("lh_rdata", mif.rdata_o, 32'hFFFF_8234);
    xfer(1'b0, 2'd1, 1'b0, 32'h0001_FFFF, 32'd0, 1'b0, dc);
    check("lhu_rdata", mif.rdata_o, 32'h0000_8234);

    // Back-to-back store then load with req held throughout
    xfer(1'b1, 2'd2, 1'b0, 32'h0000_0200, 32'h1234_5678, 1'b1, dc);
    check("b2b_st_done", 32'(dc), 32'd4);
    xfer(1'b0, 2'd2, 1'b0, 32'h0000_0200, 32'd0, 1'b0, dc);
    check("b2b_ld_done", 32'(dc), 32'd5);
    check("b2b_rdata", mif.rdata_o, 32'h1234_5678);

    // Reset in cycle 2 of a word store
    seen_done = 1'b0;
    mif.req_i = 1'b1;
    mif.we_i = 1'b1;
    mif.size_i = 2'd2;
    mif.sext_i = 1'b0;
    mif.addr_i = 32'h0000_0300;
    mif.wdata_i = 32'hCAFE_F00D;
    repeat (3) begin
      @(negedge clk);
      if (mif.done_o) seen_done = 1'b1;
    end
    check("rst_mid_wr_before", 32'(ram_wr), 32'd1);
    rst = 1'b1;
    mif.req_i = 1'b0;
    #1 check("rst_mid_wr_gate", 32'(ram_wr), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_busy", 32'(mif.busy_o), 32'd0);
    check("rst_mid_rdata", mif.rdata_o, 32'd0);
    check("rst_mid_ram_a", 32'(ram_a), 32'd0);
    repeat (3) begin
      @(negedge clk);
      if (mif.done_o) seen_done = 1'b1;
    end
    check("rst_mid_no_done", 32'(seen_done), 32'd0);
    check("rst_mid_ram", {ram[17'h303], ram[17'h302], ram[17'h301], ram[17'h300]},
          32'h0000_F00D);
    xfer(1'b0, 2'd0, 1'b0, 32'h0000_0301, 32'd0, 1'b0, dc);
    check("rst_after_done", 32'(dc), 32'd2);
    check("rst_after_rdata", mif.rdata_o, 32'h0000_00F0);

`ifdef MEM_CTRL_PERF_EN
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    xfer(1'b0, 2'd0, 1'b1, 32'h0000_0100, 32'd0, 1'b0, dc);
    xfer(1'b0, 2'd1, 1'b1, 32'h0001_FFFF, 32'd0, 1'b0, dc);
    xfer(1'b0, 2'd2, 1'b0, 32'h0000_0200, 32'd0, 1'b0, dc);
    xfer(1'b1, 2'd2, 1'b0, 32'h0000_0400, 32'h0102_0304, 1'b0, dc);
    xfer(1'b1, 2'd2, 1'b0, 32'h0000_0404, 32'h0506_0708, 1'b0, dc);
    check("perf_ld", perf_ld, 32'd3);
    check("perf_st", perf_st, 32'd2);
    // 3 + 4 + 6 load stall cycles, 5 + 5 store stall cycles
    check("perf_stall", perf_stall, 32'd23);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
